peri_leds_pwm: RTL and testbench
================================

// Module: peri_leds_pwm
// PURPOSE
//   Parametrised LED peripheral, successor to the fixed 16-bit LED register. Per-LED static on/off,
//   PWM brightness and blink, programmed through a word-addressed register bank on the data bus.
//   Sits beside the other memory-mapped peripherals; the address decoder drives we_i/addr_i.
// PARAMETERS
//   N_LEDS   16  number of LED channels (1..32)
//   PWM_BITS 8   PWM counter / duty width
//   PRESC_W  16  prescaler reload width
//   BLINK_W  8   blink period width (in PWM frames)
//   ADDR_W   6   word-address width; must satisfy 8+N_LEDS <= 2**ADDR_W
// PORTS
//   clk_i      in   1        system clock
//   reset_n_i  in   1        asynchronous reset, active low
//   we_i       in   1        write strobe, one word per cycle
//   addr_i     in   ADDR_W   word address
//   data_i     in   32       write data
//   rdata_o    out  32       read data, combinational from addr_i
//   leds_o     out  N_LEDS   LED drive, registered
// BEHAVIOUR
//   Register map (unused bits read 0, unmapped addresses read 0 / writes ignored):
//     0 CTRL bit0 EN; 1 VALUE[N-1:0]; 2 PWM_EN[N-1:0]; 3 BLINK_EN[N-1:0];
//     4 PRESC[PRESC_W-1:0]; 5 BLINK_PER[BLINK_W-1:0]; 8+i DUTY_i[PWM_BITS-1:0] (shadow).
//   Reset: all registers 0, active duties 0, counters 0, blink_phase 1, leds_o 0.
//   Writes take effect at the clock edge where we_i=1; leds_o reflects them one edge later.
//   Prescaler: pcnt counts up each cycle while EN; tick when pcnt >= PRESC, then pcnt <- 0.
//     PRESC=0 -> tick every cycle. PRESC lowered below pcnt -> tick next cycle (>= compare).
//   PWM: on tick, wcnt <- wcnt+1, wrapping 2**PWM_BITS-1 -> 0; wrap tick = frame end.
//     pwm_on[i] = (wcnt < duty_act[i]) | (duty_act[i] == all-ones). duty 0 = always off.
//   Duty shadowing: DUTY_i writes update shadow only; duty_act <- shadow on every frame end,
//     and continuously while EN=0. Write coinciding with frame end: new value loads that edge.
//   Blink: on frame end, fcnt <- fcnt+1; when fcnt reaches BLINK_PER-1, fcnt <- 0 and
//     blink_phase toggles. BLINK_PER=0 -> blink_phase held 1, fcnt held 0.
//   Output (registered): leds_o[i] <- EN & VALUE[i] & (~PWM_EN[i] | pwm_on[i])
//                                      & (~BLINK_EN[i] | blink_phase).
//   EN=0: pcnt, wcnt, fcnt held 0, blink_phase 1, leds_o 0 next edge. EN 0->1: counting
//     starts from 0 on the same edge; first frame uses current shadows.
//   Writing BLINK_PER/PRESC mid-run does not reset wcnt; writing BLINK_PER resets fcnt.
//   Reset mid-operation: everything returns to reset values immediately, asynchronously;
//     release is synchronous to the next clk_i edge.
// TESTING
//   Reset: hold reset_n_i low with we_i toggling -> leds_o=0, all reads 0; release -> still 0.
//   Static: CTRL=1, VALUE=0xA5A5 -> leds_o=0xA5A5 exactly one edge after the write; CTRL=0 -> 0.
//   PWM: PRESC=0, PWM_EN=0x0001, DUTY_0=64, VALUE=1, EN=1 -> leds_o[0] high 64 of 256 cycles per
//     frame after the first frame end; DUTY_0=0 -> never high; DUTY_0=255 -> always high.
//   Shadow: change DUTY_0 64->192 mid-frame -> current frame keeps 64, next frame shows 192;
//     readback of addr 8 returns 192 immediately.
//   Blink: PRESC=0, BLINK_EN=0x8000, VALUE=0x8000, BLINK_PER=2 -> leds_o[15] toggles every
//     512 cycles; BLINK_PER=0 -> steady on.
//   Boundaries: PRESC 1000->10 while pcnt=500 -> tick next cycle; write to addr 63 and read
//     addr 6 -> 0, no state change; reset asserted mid-frame -> leds_o=0 with no clock edge.

Source files
------------

// File: rtl/peri_leds_pwm.sv
// Memory-mapped LED peripheral: per-channel static on/off, PWM brightness
// with frame-synchronous duty shadowing, and frame-counted blink.
module peri_leds_pwm #(
    parameter int N_LEDS   = 16,
    parameter int PWM_BITS = 8,
    parameter int PRESC_W  = 16,
    parameter int BLINK_W  = 8,
    parameter int ADDR_W   = 6
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       rdata_o,
    output logic [N_LEDS-1:0] leds_o
);

    localparam logic [ADDR_W-1:0] A_CTRL      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_VALUE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_PWM_EN    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_BLINK_EN  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_PRESC     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_BLINK_PER = ADDR_W'(5);
    localparam int                DUTY_BASE   = 8;

    // Programmed registers
    logic                en;
    logic [N_LEDS-1:0]   value;
    logic [N_LEDS-1:0]   pwm_en;
    logic [N_LEDS-1:0]   blink_en;
    logic [PRESC_W-1:0]  presc;
    logic [BLINK_W-1:0]  blink_per;
    logic [PWM_BITS-1:0] duty_sh  [N_LEDS];
    logic [PWM_BITS-1:0] duty_act [N_LEDS];

    // Timebase state
    logic [PRESC_W-1:0]  pcnt;
    logic [PWM_BITS-1:0] wcnt;
    logic [BLINK_W-1:0]  fcnt;
    logic                blink_phase;

    // Decoded strobes and derived conditions
    logic                wr_ctrl, wr_value, wr_pwm_en, wr_blink_en;
    logic                wr_presc, wr_blink_per;
    logic [N_LEDS-1:0]   wr_duty;
    logic                tick;
    logic                frame_end;
    logic [N_LEDS-1:0]   pwm_on;

    assign wr_ctrl      = we_i && (addr_i == A_CTRL);
    assign wr_value     = we_i && (addr_i == A_VALUE);
    assign wr_pwm_en    = we_i && (addr_i == A_PWM_EN);
    assign wr_blink_en  = we_i && (addr_i == A_BLINK_EN);
    assign wr_presc     = we_i && (addr_i == A_PRESC);
    assign wr_blink_per = we_i && (addr_i == A_BLINK_PER);

    // Lowering PRESC below the running count still ticks on the next cycle
    // because the compare is >= rather than ==.
    assign tick      = en && (pcnt >= presc);
    assign frame_end = tick && (wcnt == '1);

    // Per-channel duty write strobes
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_duty = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            wr_duty[i] = we_i && (addr_i == ADDR_W'(DUTY_BASE + i));
        end
    end

    // Register bank writes
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            en        <= 1'b0;
            value     <= '0;
            pwm_en    <= '0;
            blink_en  <= '0;
            presc     <= '0;
            blink_per <= '0;
            // NOTE: the duty arrays are small flop banks, not RAM, so they take the reset like any register.
            for (int i = 0; i < N_LEDS; i++) begin
                duty_sh[i] <= '0;
            end
        end else begin
            if (wr_ctrl)      en        <= data_i[0];
            if (wr_value)     value     <= data_i[N_LEDS-1:0];
            if (wr_pwm_en)    pwm_en    <= data_i[N_LEDS-1:0];
            if (wr_blink_en)  blink_en  <= data_i[N_LEDS-1:0];
            if (wr_presc)     presc     <= data_i[PRESC_W-1:0];
            if (wr_blink_per) blink_per <= data_i[BLINK_W-1:0];
            for (int i = 0; i < N_LEDS; i++) begin
                if (wr_duty[i]) duty_sh[i] <= data_i[PWM_BITS-1:0];
            end
        end
    end

    // Active duties follow the shadows at frame end, and continuously while disabled;
    // a shadow write landing on the same edge is forwarded straight in.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < N_LEDS; i++) begin
                duty_act[i] <= '0;
            end
        end else if (!en || frame_end) begin
            for (int i = 0; i < N_LEDS; i++) begin
                duty_act[i] <= wr_duty[i] ? data_i[PWM_BITS-1:0] : duty_sh[i];
            end
        end
    end

    // Prescaler, PWM frame counter and blink divider
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pcnt        <= '0;
            wcnt        <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b1;
        end else if (!en) begin
            pcnt        <= '0;
            wcnt        <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b1;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) wcnt <= wcnt + 1'b1;

            if (blink_per == '0) blink_phase <= 1'b1;

            // A new blink period restarts the frame count so the first
            // phase under the new setting has its full length.
            if (wr_blink_per || (blink_per == '0)) begin
                fcnt <= '0;
            end else if (frame_end) begin
                if (fcnt >= blink_per - 1'b1) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // PWM compare; an all-ones duty means fully on
    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            pwm_on[i] = (wcnt < duty_act[i]) || (&duty_act[i]);
        end
    end

    // Registered LED drive
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            leds_o <= '0;
        end else begin
            leds_o <= {N_LEDS{en}} & value
                      & (~pwm_en | pwm_on)
                      & (~blink_en | {N_LEDS{blink_phase}});
        end
    end

    // Read mux, combinational from the address; duty reads return the shadow
    always_comb begin
        rdata_o = '0;
        case (addr_i)
            A_CTRL:      rdata_o[0]           = en;
            A_VALUE:     rdata_o[N_LEDS-1:0]  = value;
            A_PWM_EN:    rdata_o[N_LEDS-1:0]  = pwm_en;
            A_BLINK_EN:  rdata_o[N_LEDS-1:0]  = blink_en;
            A_PRESC:     rdata_o[PRESC_W-1:0] = presc;
            A_BLINK_PER: rdata_o[BLINK_W-1:0] = blink_per;
            default:     rdata_o              = '0;
        endcase
        for (int i = 0; i < N_LEDS; i++) begin
            if (addr_i == ADDR_W'(DUTY_BASE + i)) rdata_o[PWM_BITS-1:0] = duty_sh[i];
        end
    end

endmodule

// File: tb/tb_peri_leds_pwm.sv
// Directed bench for peri_leds_pwm: reset, static drive, PWM duty, duty
// shadowing, blink, prescaler compare, unmapped access and async reset.
module tb_peri_leds_pwm;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        we_i = 1'b0;
    logic [5:0]  addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] rdata_o;
    logic [15:0] leds_o;

    int n_checks = 0;
    int n_errors = 0;

    peri_leds_pwm dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .rdata_o   (rdata_o),
        .leds_o    (leds_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns at the falling edge after it.
    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        we_i   = 1'b1;
        addr_i = a;
        data_i = d;
        @(negedge clk_i);
        we_i   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        check(tag, rdata_o, exp);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic count_hi(input int n, input int b, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk_i);
            if (leds_o[b]) hi++;
        end
    endtask

    int hi;

    initial begin
        // ---------------- reset held with write traffic ----------------
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            we_i   = k[0];
            addr_i = (k < 3) ? 6'd0 : 6'd1;
            data_i = 32'hFFFF_FFFF;
        end
        @(negedge clk_i);
        we_i = 1'b0;
        check("reset_leds", 32'(leds_o), 32'h0);
        rd("reset_ctrl",  6'd0, 32'h0);
        rd("reset_value", 6'd1, 32'h0);
        rd("reset_presc", 6'd4, 32'h0);
        rd("reset_duty0", 6'd8, 32'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        skip(3);
        check("post_release_leds", 32'(leds_o), 32'h0);

        // ---------------- static drive ----------------
        wr(6'd0, 32'h1);
        wr(6'd1, 32'hA5A5);
        check("static_not_yet", 32'(leds_o), 32'h0);
        skip(1);
        check("static_on", 32'(leds_o), 32'hA5A5);
        rd("static_rd_value", 6'd1, 32'hA5A5);
        wr(6'd0, 32'h0);
        check("disable_lag", 32'(leds_o), 32'hA5A5);
        skip(1);
        check("disable_off", 32'(leds_o), 32'h0);

        // ---------------- PWM duty 64 ----------------
        wr(6'd4, 32'd0);
        wr(6'd2, 32'h1);
        wr(6'd8, 32'd64);
        wr(6'd1, 32'h1);
        wr(6'd0, 32'h1);
        hi = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk_i);
            if (leds_o[0]) hi++;
            if (k == 64) check("pwm_last_on",   32'(leds_o[0]), 32'h1);
            if (k == 65) check("pwm_first_off", 32'(leds_o[0]), 32'h0);
        end
        check("pwm64_frame1", 32'(hi), 32'd64);
        count_hi(256, 0, hi);
        check("pwm64_frame2", 32'(hi), 32'd64);

        wr(6'd8, 32'd0);
        skip(256);
        count_hi(256, 0, hi);
        check("pwm_duty0", 32'(hi), 32'd0);

        wr(6'd8, 32'd255);
        skip(256);
        count_hi(256, 0, hi);
        check("pwm_duty255", 32'(hi), 32'd256);

        // ---------------- duty shadowing ----------------
        wr(6'd0, 32'h0);
        wr(6'd8, 32'd64);
        wr(6'd0, 32'h1);
        skip(99);
        wr(6'd8, 32'd192);
        rd("shadow_readback", 6'd8, 32'd192);
        count_hi(156, 0, hi);
        check("shadow_cur_frame", 32'(hi), 32'd0);
        count_hi(256, 0, hi);
        check("shadow_next_frame", 32'(hi), 32'd192);

        // ---------------- blink ----------------
        wr(6'd0, 32'h0);
        wr(6'd2, 32'h0);
        wr(6'd1, 32'h8000);
        wr(6'd3, 32'h8000);
        wr(6'd5, 32'd2);
        wr(6'd0, 32'h1);
        count_hi(512, 15, hi);
        check("blink_phase_a", 32'(hi), 32'd512);
        count_hi(512, 15, hi);
        check("blink_phase_b", 32'(hi), 32'd0);
        count_hi(512, 15, hi);
        check("blink_phase_c", 32'(hi), 32'd512);
        check("blink_bit0_off", 32'(leds_o[0]), 32'h0);
        wr(6'd5, 32'd0);
        skip(4);
        count_hi(300, 15, hi);
        check("blink_per0_steady", 32'(hi), 32'd300);

        // ---------------- prescaler lowered below count ----------------
        wr(6'd0, 32'h0);
        wr(6'd3, 32'h0);
        wr(6'd1, 32'h1);
        wr(6'd2, 32'h1);
        wr(6'd8, 32'd1);
        wr(6'd4, 32'd1000);
        wr(6'd0, 32'h1);
        skip(499);
        wr(6'd4, 32'd10);
        check("presc_before_tick", 32'(leds_o[0]), 32'h1);
        skip(1);
        check("presc_tick_edge", 32'(leds_o[0]), 32'h1);
        skip(1);
        check("presc_after_tick", 32'(leds_o[0]), 32'h0);

        // ---------------- unmapped addresses ----------------
        wr(6'd63, 32'hFFFF_FFFF);
        rd("unmapped_rd6",  6'd6,  32'h0);
        rd("unmapped_rd63", 6'd63, 32'h0);
        rd("unmapped_rd24", 6'd24, 32'h0);
        rd("keep_ctrl",     6'd0,  32'h1);
        rd("keep_presc",    6'd4,  32'd10);
        rd("keep_duty0",    6'd8,  32'd1);
        rd("keep_blinkper", 6'd5,  32'd0);

        // ---------------- asynchronous reset mid-frame ----------------
        @(negedge clk_i);
        wr(6'd2, 32'h0);
        skip(2);
        check("pre_reset_on", 32'(leds_o), 32'h1);
        #1;
        reset_n_i = 1'b0;
        #1;
        check("async_reset_leds", 32'(leds_o), 32'h0);
        rd("async_reset_value", 6'd1, 32'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        skip(3);
        check("post_reset_leds", 32'(leds_o), 32'h0);
        rd("post_reset_ctrl", 6'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
